// File: rtl/jesd204b_tx_link_seq.sv
`default_nettype none
// ============================================================================
// Module   : jesd204b_tx_link_seq
// Purpose  : JESD204B transmit link-layer sequencer. Steps the lane datapath
//            through CGS, ILAS and DATA. ILAS starts only on an LMFC
//            boundary. Per-frame insertion strobes (/R/, /A/, /Q/) go to the
//            8b/10b symbol mux.
// Ports    : clk, rst_n          device clock, async active-low reset
//            i_frame_clk         1-cycle frame pulse
//            i_lmfc_clk          1-cycle LMFC pulse (coincident with a frame)
//            i_K                 frames per multiframe minus 1
//            i_sync_n            SYNC~ (clk domain), low = request sync
//            o_state             0=CGS 1=ILAS 2=DATA
//            o_send_k            K28.5 on all octets
//            o_ilas_*            ILAS progress and insertion strobes
//            o_data_en           user data enabled
//            o_align_err         sticky ILAS wrap/LMFC misalignment
//            o_resync_cnt        saturating DATA->CGS count
// Revision : 1.0 - initial release
// ============================================================================
module jesd204b_tx_link_seq #(
  parameter int ILAS_MF         = 4,
  parameter int SYNC_ERR_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_frame_clk,
  input  logic       i_lmfc_clk,
  input  logic [4:0] i_K,
  input  logic       i_sync_n,
  output logic [1:0] o_state,
  output logic       o_send_k,
  output logic       o_ilas_active,
  output logic [2:0] o_ilas_mf_idx,
  output logic       o_ilas_start_mf,
  output logic       o_ilas_end_mf,
  output logic       o_ilas_cfg,
  output logic       o_data_en,
  output logic       o_align_err,
  output logic [7:0] o_resync_cnt
);

  localparam logic [1:0] ST_CGS  = 2'd0;
  localparam logic [1:0] ST_ILAS = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic [2:0] LAST_MF   = 3'(ILAS_MF - 1);
  localparam logic [7:0] LOW_LIMIT = 8'(SYNC_ERR_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [4:0] k_reg_q, k_reg_d;
  logic [4:0] frame_idx_q, frame_idx_d;
  logic [2:0] mf_idx_q, mf_idx_d;
  logic [7:0] low_cnt_q, low_cnt_d;
  logic       align_err_q, align_err_d;
  logic [7:0] resync_cnt_q, resync_cnt_d;

  logic send_k_q, send_k_d;
  logic ilas_active_q, ilas_active_d;
  logic start_mf_q, start_mf_d;
  logic end_mf_q, end_mf_d;
  logic cfg_q, cfg_d;
  logic data_en_q, data_en_d;

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_CGS;
      k_reg_q      <= '0;
      frame_idx_q  <= '0;
      mf_idx_q     <= '0;
      low_cnt_q    <= '0;
      align_err_q  <= 1'b0;
      resync_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      k_reg_q      <= k_reg_d;
      frame_idx_q  <= frame_idx_d;
      mf_idx_q     <= mf_idx_d;
      low_cnt_q    <= low_cnt_d;
      align_err_q  <= align_err_d;
      resync_cnt_q <= resync_cnt_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d      = state_q;
    k_reg_d      = k_reg_q;
    frame_idx_d  = frame_idx_q;
    mf_idx_d     = mf_idx_q;
    low_cnt_d    = '0;
    align_err_d  = align_err_q;
    resync_cnt_d = resync_cnt_q;
    case (state_q)
      ST_CGS: begin
        // The entry pulse itself is frame 0 of multiframe 0.
        if (i_lmfc_clk && i_sync_n) begin
          state_d     = ST_ILAS;
          k_reg_d     = i_K;
          frame_idx_d = '0;
          mf_idx_d    = '0;
        end
      end
      ST_ILAS: begin
        // SYNC~ low takes priority over any frame wrap on the same cycle.
        if (!i_sync_n) begin
          state_d     = ST_CGS;
          frame_idx_d = '0;
          mf_idx_d    = '0;
        end else if (i_frame_clk) begin
          if (frame_idx_q < k_reg_q) begin
            frame_idx_d = frame_idx_q + 5'd1;
          end else begin
            frame_idx_d = '0;
            if (!i_lmfc_clk) begin
              align_err_d = 1'b1;
            end
            if (mf_idx_q == LAST_MF) begin
              state_d  = ST_DATA;
              mf_idx_d = '0;
            end else begin
              mf_idx_d = mf_idx_q + 3'd1;
            end
          end
        end
      end
      ST_DATA: begin
        // Only a run of SYNC_ERR_CYCLES low cycles forces a resync;
        // shorter error-report pulses just reset the run length.
        if (!i_sync_n) begin
          if (low_cnt_q == LOW_LIMIT) begin
            state_d = ST_CGS;
            if (resync_cnt_q != 8'hFF) begin
              resync_cnt_d = resync_cnt_q + 8'd1;
            end
          end else begin
            low_cnt_d = low_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = ST_CGS;
      end
    endcase
  end

  // Output decode from the next-state values so that the registered
  // outputs line up with the state held after the same edge.
  always_comb begin
    send_k_d      = (state_d == ST_CGS);
    ilas_active_d = (state_d == ST_ILAS);
    start_mf_d    = (state_d == ST_ILAS) && (frame_idx_d == 5'd0);
    end_mf_d      = (state_d == ST_ILAS) && (frame_idx_d == k_reg_d);
    cfg_d         = (state_d == ST_ILAS) && (mf_idx_d == 3'd1);
    data_en_d     = (state_d == ST_DATA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      send_k_q      <= 1'b1;
      ilas_active_q <= 1'b0;
      start_mf_q    <= 1'b0;
      end_mf_q      <= 1'b0;
      cfg_q         <= 1'b0;
      data_en_q     <= 1'b0;
    end else begin
      send_k_q      <= send_k_d;
      ilas_active_q <= ilas_active_d;
      start_mf_q    <= start_mf_d;
      end_mf_q      <= end_mf_d;
      cfg_q         <= cfg_d;
      data_en_q     <= data_en_d;
    end
  end

  // mf_idx is held at zero outside ILAS, so it drives the port directly.
  assign o_state         = state_q;
  assign o_send_k        = send_k_q;
  assign o_ilas_active   = ilas_active_q;
  assign o_ilas_mf_idx   = mf_idx_q;
  assign o_ilas_start_mf = start_mf_q;
  assign o_ilas_end_mf   = end_mf_q;
  assign o_ilas_cfg      = cfg_q;
  assign o_data_en       = data_en_q;
  assign o_align_err     = align_err_q;
  assign o_resync_cnt    = resync_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_jesd204b_tx_link_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_jesd204b_tx_link_seq
// Purpose  : Self-checking bench for jesd204b_tx_link_seq. Two instances:
//            dut (ILAS_MF=4) and dut1 (ILAS_MF=1) share all inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jesd204b_tx_link_seq;

  logic       clk;
  logic       rst_n;
  logic       i_frame_clk;
  logic       i_lmfc_clk;
  logic [4:0] i_K;
  logic       i_sync_n;

  logic [1:0] o_state,       o1_state;
  logic       o_send_k,      o1_send_k;
  logic       o_ilas_active, o1_ilas_active;
  logic [2:0] o_ilas_mf_idx, o1_ilas_mf_idx;
  logic       o_start,       o1_start;
  logic       o_endm,        o1_endm;
  logic       o_cfg,         o1_cfg;
  logic       o_data_en,     o1_data_en;
  logic       o_align_err,   o1_align_err;
  logic [7:0] o_resync_cnt,  o1_resync_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [1:0] st;
    logic       sk;
    logic       act;
    logic [2:0] mf;
    logic       sm;
    logic       em;
    logic       cfg;
    logic       den;
    logic       aerr;
    logic [7:0] rc;
  } obs_t;

  obs_t sb[$];
  obs_t sb1[$];
  obs_t got, exp_v;

  jesd204b_tx_link_seq #(.ILAS_MF(4), .SYNC_ERR_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_frame_clk(i_frame_clk), .i_lmfc_clk(i_lmfc_clk),
    .i_K(i_K), .i_sync_n(i_sync_n), .o_state(o_state), .o_send_k(o_send_k),
    .o_ilas_active(o_ilas_active), .o_ilas_mf_idx(o_ilas_mf_idx),
    .o_ilas_start_mf(o_start), .o_ilas_end_mf(o_endm), .o_ilas_cfg(o_cfg),
    .o_data_en(o_data_en), .o_align_err(o_align_err), .o_resync_cnt(o_resync_cnt)
  );

  jesd204b_tx_link_seq #(.ILAS_MF(1), .SYNC_ERR_CYCLES(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_frame_clk(i_frame_clk), .i_lmfc_clk(i_lmfc_clk),
    .i_K(i_K), .i_sync_n(i_sync_n), .o_state(o1_state), .o_send_k(o1_send_k),
    .o_ilas_active(o1_ilas_active), .o_ilas_mf_idx(o1_ilas_mf_idx),
    .o_ilas_start_mf(o1_start), .o_ilas_end_mf(o1_endm), .o_ilas_cfg(o1_cfg),
    .o_data_en(o1_data_en), .o_align_err(o1_align_err), .o_resync_cnt(o1_resync_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic obs_t obs_main();
    return {o_state, o_send_k, o_ilas_active, o_ilas_mf_idx, o_start, o_endm,
            o_cfg, o_data_en, o_align_err, o_resync_cnt};
  endfunction

  function automatic obs_t obs_dut1();
    return {o1_state, o1_send_k, o1_ilas_active, o1_ilas_mf_idx, o1_start, o1_endm,
            o1_cfg, o1_data_en, o1_align_err, o1_resync_cnt};
  endfunction

  // Expected output vector for a given state; derived flags follow the state.
  function automatic obs_t mk(input logic [1:0] st, input logic [2:0] mf, input logic sm,
                              input logic em, input logic cfg, input logic ae,
                              input logic [7:0] rc);
    obs_t o;
    o.st   = st;
    o.sk   = (st == 2'd0);
    o.act  = (st == 2'd1);
    o.mf   = mf;
    o.sm   = sm;
    o.em   = em;
    o.cfg  = cfg;
    o.den  = (st == 2'd2);
    o.aerr = ae;
    o.rc   = rc;
    return o;
  endfunction

  // Expected ILAS output after the m-th ILAS frame (m=0 is the entry frame).
  function automatic obs_t mk_ilas(input int m, input int k, input logic ae,
                                   input logic [7:0] rc);
    int fi;
    int mf;
    fi = m % (k + 1);
    mf = m / (k + 1);
    return mk(2'd1, 3'(mf), fi == 0, fi == k, mf == 1, ae, rc);
  endfunction

  task automatic drive(input logic f, input logic l, input logic s);
    i_frame_clk = f;
    i_lmfc_clk  = l;
    i_sync_n    = s;
    @(posedge clk);
    #1;
    i_frame_clk = 1'b0;
    i_lmfc_clk  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_sync_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    i_K = 5'd3;
    i_sync_n = 1'b0;
    i_frame_clk = 1'b0;
    i_lmfc_clk = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.push_back(mk(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    #1;
    exp_v = sb.pop_front(); got = obs_main(); n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected %h", got, exp_v);
    end
    // Held reset across an edge with an ILAS entry condition present.
    sb.push_back(mk(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    drive(1'b1, 1'b1, 1'b1);
    exp_v = sb.pop_front(); got = obs_main(); n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL reset_held: got %h expected %h", got, exp_v);
    end
    i_sync_n = 1'b0;
    rst_n = 1'b1;
  endtask

  // K=3: SYNC~ rises mid-multiframe, ILAS waits for LMFC, runs 16 frames.
  task automatic test_ilas_sequence();
    for (int f = 0; f <= 24; f++) begin
      logic s;
      obs_t e;
      s = (f >= 5);
      if (f < 8)       e = mk(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      else if (f < 24) e = mk_ilas(f - 8, 3, 1'b0, 8'd0);
      else             e = mk(2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      sb.push_back(e);
      drive(1'b1, (f % 4) == 0, s);
      if (f == 8) i_K = 5'd1;  // must be ignored until next ILAS entry
      exp_v = sb.pop_front(); got = obs_main(); n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL ilas_pulse f=%0d: got %h expected %h", f, got, exp_v);
      end
      sb.push_back(e);
      drive(1'b0, 1'b0, s);
      exp_v = sb.pop_front(); got = obs_main(); n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL ilas_idle f=%0d: got %h expected %h", f, got, exp_v);
      end
    end
  endtask

  // DATA: 7-cycle low pulse ignored, 8-cycle low forces resync.
  task automatic test_data_resync();
    for (int c = 0; c < 16; c++) begin
      logic s;
      obs_t e;
      s = (c == 7);
      if (c < 15) e = mk(2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      else        e = mk(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
      sb.push_back(e);
      drive(1'b0, 1'b0, s);
      exp_v = sb.pop_front(); got = obs_main(); n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL data_sync c=%0d: got %h expected %h", c, got, exp_v);
      end
    end
    sb.push_back(mk(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
    drive(1'b1, 1'b1, 1'b0);
    exp_v = sb.pop_front(); got = obs_main(); n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL cgs_hold: got %h expected %h", got, exp_v);
    end
  endtask

  // ILAS abort by SYNC~ at frame 6, re-entry on next LMFC, then SYNC~ fall
  // coincident with a multiframe wrap.
  task automatic test_ilas_abort();
    i_K = 5'd3;
    for (int f = 1; f <= 16; f++) begin
      obs_t ep;
      obs_t ei;
      obs_t cgs;
      cgs = mk(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
      if (f >= 4 && f <= 10)       ep = mk_ilas(f - 4, 3, 1'b0, 8'd1);
      else if (f >= 12 && f <= 15) ep = mk_ilas(f - 12, 3, 1'b0, 8'd1);
      else                         ep = cgs;
      ei = (f == 10) ? cgs : ep;
      sb.push_back(ep);
      drive(1'b1, (f % 4) == 0, f != 16);
      exp_v = sb.pop_front(); got = obs_main(); n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL abort_pulse f=%0d: got %h expected %h", f, got, exp_v);
      end
      sb.push_back(ei);
      drive(1'b0, 1'b0, f != 10);
      exp_v = sb.pop_front(); got = obs_main(); n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL abort_idle f=%0d: got %h expected %h", f, got, exp_v);
      end
    end
  endtask

  // LMFC one frame late: align error at first wrap, sticky until reset.
  task automatic test_align_err();
    i_K = 5'd3;
    do_reset();
    for (int f = 0; f <= 17; f++) begin
      logic l;
      obs_t e;
      l = (f == 0) || ((f % 4) == 1);
      if (f < 16) e = mk_ilas(f, 3, f >= 4, 8'd0);
      else        e = mk(2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
      sb.push_back(e);
      drive(1'b1, l, 1'b1);
      exp_v = sb.pop_front(); got = obs_main(); n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL align f=%0d: got %h expected %h", f, got, exp_v);
      end
    end
    #2;
    rst_n = 1'b0;
    sb.push_back(mk(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    #1;
    exp_v = sb.pop_front(); got = obs_main(); n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL align_clear: got %h expected %h", got, exp_v);
    end
    rst_n = 1'b1;
  endtask

  // K=0 on both instances; async reset mid-DATA.
  task automatic test_k0();
    i_K = 5'd0;
    do_reset();
    for (int f = 0; f <= 4; f++) begin
      sb.push_back((f < 4) ? mk(2'd1, 3'(f), 1'b1, 1'b1, f == 1, 1'b0, 8'd0)
                           : mk(2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
      sb1.push_back((f == 0) ? mk(2'd1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0)
                             : mk(2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
      drive(1'b1, 1'b1, 1'b1);
      exp_v = sb.pop_front(); got = obs_main(); n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL k0 f=%0d: got %h expected %h", f, got, exp_v);
      end
      exp_v = sb1.pop_front(); got = obs_dut1(); n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL k0_mf1 f=%0d: got %h expected %h", f, got, exp_v);
      end
    end
    #2;
    rst_n = 1'b0;
    sb.push_back(mk(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    sb1.push_back(mk(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    #1;
    exp_v = sb.pop_front(); got = obs_main(); n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL k0_async_rst: got %h expected %h", got, exp_v);
    end
    exp_v = sb1.pop_front(); got = obs_dut1(); n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL k0_mf1_async_rst: got %h expected %h", got, exp_v);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ilas_sequence();
    test_data_resync();
    test_ilas_abort();
    test_align_err();
    test_k0();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
